// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, oversampling bit timer,
// start/data/stop framing FSM and a valid/ack byte handshake with
// framing-error and overrun reporting.
module uart_rx #(
  parameter int SYS_CLK_RATE = 32,
  parameter int BAUD_RATE    = 1,
  parameter int OVERSAMPLE   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = SYS_CLK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID   = TW'(OVERSAMPLE / 2 - 1);

  generate
    if ((DIV < 1) || (DIV * BAUD_RATE * OVERSAMPLE != SYS_CLK_RATE) ||
        (OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_params
      $error("uart_rx: clock rate must be an integer multiple of BAUD_RATE*OVERSAMPLE, OVERSAMPLE even and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state, state_next;

  logic          rx_p0, rxs;
  logic          vld_p0, vld_p1;
  logic          armed;
  logic [PW-1:0] presc;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  logic tick, bit_end;
  logic start_go, sample_start, data_sample, good_stop, bad_stop;
  logic load, drop;

  // Stage p0 -> p1: two-flop synchroniser. vld_pN marks when rxs carries a
  // real line sample rather than the reset value, so a line already low
  // coming out of reset is not mistaken for a falling edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_p0  <= 1'b1;
      rxs    <= 1'b1;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      rx_p0  <= rx;
      rxs    <= rx_p0;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
      if (vld_p1 && rxs) begin
        armed <= 1'b1;
      end
    end
  end

  // FSM state register; rx_busy is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rx_busy <= 1'b0;
    end else begin
      state   <= state_next;
      rx_busy <= (state_next != IDLE);
    end
  end

  // Next-state decode and the per-cycle sampling strobes.
  always_comb begin
    state_next   = state;
    start_go     = 1'b0;
    sample_start = 1'b0;
    data_sample  = 1'b0;
    good_stop    = 1'b0;
    bad_stop     = 1'b0;
    tick         = (state != IDLE) && (presc == PRESC_LAST);
    bit_end      = tick && (tick_cnt == TICK_LAST);
    case (state)
      IDLE: begin
        if (armed && !rxs) begin
          start_go   = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (tick && (tick_cnt == TICK_MID)) begin
          sample_start = 1'b1;
          state_next   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          data_sample = 1'b1;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (rxs) begin
            good_stop  = 1'b1;
            state_next = IDLE;
          end else begin
            bad_stop   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    load = good_stop && (!rx_valid || rx_ack);
    drop = good_stop && rx_valid && !rx_ack;
  end

  // Prescaler, tick-within-bit and bit counters; all restart on a new frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (start_go || (state == IDLE)) begin
        presc <= '0;
      end else if (tick) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end

      if (start_go || sample_start) begin
        tick_cnt <= '0;
      end else if (tick) begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      end

      if (start_go) begin
        bit_cnt <= '0;
      end else if (data_sample) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Data shift register: first received bit walks down to bit 0.
  always_ff @(posedge clk) begin
    if (data_sample) begin
      shift <= {rxs, shift[7:1]};
    end
  end

  // Host handshake and error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (load) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 32 clk per bit: the stimulus pushes each
// byte it expects to be delivered, a monitor pops and compares on delivery.
module tb_uart_rx;

  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int fe_count = 0;
  int fe_expected = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_fe = 1'b0;

  uart_rx #(
    .SYS_CLK_RATE(32),
    .BAUD_RATE(1),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_ack(rx_ack),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_busy(rx_busy),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame, LSB first, starting right away.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      wait_clk(BIT_CLK);
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
  endtask

  // Delivery monitor: a byte is presented when rx_valid rises or when the
  // held byte is replaced while rx_valid stays high.
  always @(negedge clk) begin
    if (rst && rx_valid && (!prev_valid || rx_data != prev_data)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got %0h expected none", rx_data);
      end else begin
        exp_byte = exp_q.pop_front();
        check("rx_byte", {24'h0, rx_data}, {24'h0, exp_byte});
      end
    end
    if (frame_err) begin
      fe_count++;
      check("frame_err_one_clk", {31'h0, prev_fe}, 32'h0);
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
    prev_fe    = frame_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_busy;
    bit got;
    int lat;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", {24'h0, rx_data}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_rx_busy", {31'h0, rx_busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);

    // Line held low through reset release must not start a frame
    rx = 1'b0;
    wait_clk(2);
    rst = 1'b1;
    seen_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      seen_busy |= rx_busy;
    end
    check("no_start_after_reset", {31'h0, seen_busy}, 32'h0);
    rx = 1'b1;
    wait_clk(10);

    // Normal frame 0xA5, latency and busy
    exp_q.push_back(8'hA5);
    got = 1'b0;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int n = 1; n <= 400 && !got; n++) begin
          @(negedge clk);
          if (n == 150) check("busy_mid_frame", {31'h0, rx_busy}, 32'h1);
          if (rx_valid) begin
            got = 1'b1;
            lat = n;
          end
        end
      end
    join
    checks++;
    if (!got || lat < 300 || lat > 312) begin
      failures++;
      $display("FAIL valid_latency: got %0d clk (seen=%0d) expected 300..312", lat, got);
    end
    ack_pulse();
    @(negedge clk);
    check("ack_clears_valid", {31'h0, rx_valid}, 32'h0);
    wait_clk(5);

    // Start-bit glitch
    rx = 1'b0;
    wait_clk(8);
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy", {31'h0, rx_busy}, 32'h1);
    wait_clk(40);
    check("glitch_idle", {31'h0, rx_busy}, 32'h0);
    check("glitch_no_valid", {31'h0, rx_valid}, 32'h0);

    // Framing error followed by a held-low line
    fe_expected++;
    send_frame(8'h3C, 1'b0);
    wait_clk(2 * BIT_CLK);
    check("break_busy", {31'h0, rx_busy}, 32'h1);
    check("framing_no_valid", {31'h0, rx_valid}, 32'h0);
    rx = 1'b1;
    wait_clk(10);
    check("break_released", {31'h0, rx_busy}, 32'h0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    check("after_break_valid", {31'h0, rx_valid}, 32'h1);
    ack_pulse();
    wait_clk(5);

    // Overrun: second back-to-back frame dropped while unacknowledged
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clk(5);
    check("overrun_data_kept", {24'h0, rx_data}, 32'h11);
    check("overrun_set", {31'h0, overrun}, 32'h1);
    ack_pulse();
    @(negedge clk);
    check("overrun_ack_valid", {31'h0, rx_valid}, 32'h0);
    check("overrun_ack_clear", {31'h0, overrun}, 32'h0);
    wait_clk(5);

    // Ack coinciding with the second frame's stop-sample clock
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        repeat (10 * BIT_CLK + 306) @(posedge clk);
        #1;
        rx_ack = 1'b1;
        wait_clk(1);
        rx_ack = 1'b0;
      end
    join
    wait_clk(2);
    check("coincide_data", {24'h0, rx_data}, 32'h22);
    check("coincide_valid", {31'h0, rx_valid}, 32'h1);
    check("coincide_no_overrun", {31'h0, overrun}, 32'h0);
    ack_pulse();
    wait_clk(5);

    // Reset during bit 4 of 0xFF, then 0x5A
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_clk(5 * BIT_CLK + 10);
        rst = 1'b0;
        wait_clk(3);
        rst = 1'b1;
      end
    join
    check("midframe_reset_idle", {31'h0, rx_busy}, 32'h0);
    check("midframe_reset_no_valid", {31'h0, rx_valid}, 32'h0);
    wait_clk(10);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check("after_reset_data", {24'h0, rx_data}, 32'h5A);
    ack_pulse();
    wait_clk(20);

    check("pending_bytes", exp_q.size(), 32'h0);
    check("frame_err_count", fe_count, fe_expected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
